// File: rtl/cp0_reg.sv
// ============================================================================
// Module      : cp0_reg
// Description : MIPS32 coprocessor-0 register file fed by the MEM/WB write
//               triple, MEM-stage exception info, interrupt lines and Count.
//               Optional BadVAddr register enabled by macro CP0_BADVADDR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_reg #(
    parameter logic [31:0] PRID_VALUE   = 32'h00480102,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] badvaddr_i,
    output logic [31:0] badvaddr_o,
`endif
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0]  c_reg_badvaddr = 5'd8;
    localparam logic [4:0]  c_reg_count    = 5'd9;
    localparam logic [4:0]  c_reg_compare  = 5'd11;
    localparam logic [4:0]  c_reg_status   = 5'd12;
    localparam logic [4:0]  c_reg_cause    = 5'd13;
    localparam logic [4:0]  c_reg_epc      = 5'd14;
    localparam logic [4:0]  c_reg_prid     = 5'd15;
    localparam logic [4:0]  c_reg_config   = 5'd16;
    localparam logic [31:0] c_status_rst   = 32'h10000000;

    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q,  status_d;
    logic [31:0] cause_q,   cause_d;
    logic [31:0] epc_q,     epc_d;
    logic        timer_q,   timer_d;
`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q, badvaddr_d;
`endif

    logic        w_exc_valid;
    logic        w_exc_eret;
    logic        w_exc_addr;
    logic [4:0]  w_exc_code;

    always_comb begin
        w_exc_valid = 1'b0;
        w_exc_eret  = 1'b0;
        w_exc_addr  = 1'b0;
        w_exc_code  = 5'd0;
        case (excepttype_i)
            32'h0000_0001: begin w_exc_valid = 1'b1; w_exc_code = 5'd0;  end
            32'h0000_0008: begin w_exc_valid = 1'b1; w_exc_code = 5'd8;  end
            32'h0000_000a: begin w_exc_valid = 1'b1; w_exc_code = 5'd10; end
            32'h0000_000d: begin w_exc_valid = 1'b1; w_exc_code = 5'd13; end
            32'h0000_000c: begin w_exc_valid = 1'b1; w_exc_code = 5'd12; end
`ifdef CP0_BADVADDR_EN
            32'h0000_0004: begin w_exc_valid = 1'b1; w_exc_addr = 1'b1; w_exc_code = 5'd4; end
            32'h0000_0005: begin w_exc_valid = 1'b1; w_exc_addr = 1'b1; w_exc_code = 5'd5; end
`endif
            32'h0000_000e: w_exc_eret = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        status_d  = status_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        timer_d   = timer_q;
`ifdef CP0_BADVADDR_EN
        badvaddr_d = badvaddr_q;
`endif

        if ((compare_q != 32'd0) && (count_q == compare_q)) begin
            timer_d = 1'b1;
        end

        cause_d[15:10] = int_i;

        if (we_i) begin
            case (waddr_i)
                c_reg_count:   count_d  = wdata_i;
                c_reg_compare: begin
                    compare_d = wdata_i;
                    timer_d   = 1'b0;
                end
                c_reg_status:  status_d = wdata_i;
                c_reg_epc:     epc_d    = wdata_i;
                c_reg_cause: begin
                    cause_d[9:8] = wdata_i[9:8];
                    cause_d[22]  = wdata_i[22];
                    cause_d[23]  = wdata_i[23];
                end
                default: ;
            endcase
        end

        // Exceptions land after software writes so they win on shared fields;
        // EPC/BD only capture on the first exception (EXL sampled pre-edge).
        if (w_exc_valid) begin
            status_d[1]  = 1'b1;
            cause_d[6:2] = w_exc_code;
            if (!status_q[1]) begin
                if (is_in_delayslot_i) begin
                    epc_d       = current_inst_addr_i - 32'd4;
                    cause_d[31] = 1'b1;
                end else begin
                    epc_d       = current_inst_addr_i;
                    cause_d[31] = 1'b0;
                end
            end
        end else if (w_exc_eret) begin
            status_d[1] = 1'b0;
        end

`ifdef CP0_BADVADDR_EN
        if (w_exc_addr) begin
            badvaddr_d = badvaddr_i;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            status_q  <= c_status_rst;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
            timer_q   <= 1'b0;
`ifdef CP0_BADVADDR_EN
            badvaddr_q <= 32'd0;
`endif
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            timer_q   <= timer_d;
`ifdef CP0_BADVADDR_EN
            badvaddr_q <= badvaddr_d;
`endif
        end
    end

    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
`ifdef CP0_BADVADDR_EN
            c_reg_badvaddr: data_o = badvaddr_q;
`else
            c_reg_badvaddr: data_o = 32'd0;
`endif
            c_reg_count:    data_o = count_q;
            c_reg_compare:  data_o = compare_q;
            c_reg_status:   data_o = status_q;
            c_reg_cause:    data_o = cause_q;
            c_reg_epc:      data_o = epc_q;
            c_reg_prid:     data_o = PRID_VALUE;
            c_reg_config:   data_o = CONFIG_VALUE;
            default:        data_o = 32'd0;
        endcase
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign config_o    = CONFIG_VALUE;
    assign prid_o      = PRID_VALUE;
    assign timer_int_o = timer_q;
`ifdef CP0_BADVADDR_EN
    assign badvaddr_o  = badvaddr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cp0_reg.sv
// ============================================================================
// Module      : tb_cp0_reg
// Description : Scoreboard bench for cp0_reg; expectations are queued with
//               each stimulus and checked just after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_reg;

    localparam logic [31:0] c_prid   = 32'h00480102;
    localparam logic [31:0] c_config = 32'h00008000;

    localparam int c_sel_count   = 0;
    localparam int c_sel_compare = 1;
    localparam int c_sel_status  = 2;
    localparam int c_sel_cause   = 3;
    localparam int c_sel_epc     = 4;
    localparam int c_sel_config  = 5;
    localparam int c_sel_prid    = 6;
    localparam int c_sel_timer   = 7;
    localparam int c_sel_data    = 8;
    localparam int c_sel_badva   = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o;
    logic [31:0] config_o, prid_o;
    logic        timer_int_o;
`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_i;
    logic [31:0] badvaddr_o;
`endif

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cp0_reg #(
        .PRID_VALUE   (c_prid),
        .CONFIG_VALUE (c_config)
    ) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .wdata_i             (wdata_i),
        .raddr_i             (raddr_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
`ifdef CP0_BADVADDR_EN
        .badvaddr_i          (badvaddr_i),
        .badvaddr_o          (badvaddr_o),
`endif
        .data_o              (data_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .config_o            (config_o),
        .prid_o              (prid_o),
        .timer_int_o         (timer_int_o)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            c_sel_count:   return count_o;
            c_sel_compare: return compare_o;
            c_sel_status:  return status_o;
            c_sel_cause:   return cause_o;
            c_sel_epc:     return epc_o;
            c_sel_config:  return config_o;
            c_sel_prid:    return prid_o;
            c_sel_timer:   return {31'd0, timer_int_o};
`ifdef CP0_BADVADDR_EN
            c_sel_badva:   return badvaddr_o;
`endif
            default:       return data_o;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic expect_push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // One clock edge; drain the scoreboard, then drop one-shot stimulus.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
        we_i         = 1'b0;
        excepttype_i = 32'd0;
    endtask

    task automatic sw_write(input logic [4:0] addr, input logic [31:0] data);
        we_i    = 1'b1;
        waddr_i = addr;
        wdata_i = data;
    endtask

    task automatic raise(input logic [31:0] code, input logic [31:0] pc, input logic ds);
        excepttype_i        = code;
        current_inst_addr_i = pc;
        is_in_delayslot_i   = ds;
    endtask

    initial begin
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
        int_i = '0; excepttype_i = '0; current_inst_addr_i = '0; is_in_delayslot_i = 1'b0;
`ifdef CP0_BADVADDR_EN
        badvaddr_i = '0;
`endif

        step();
        raddr_i = 5'd15;
        expect_push("rst_count",   c_sel_count,   32'd0);
        expect_push("rst_compare", c_sel_compare, 32'd0);
        expect_push("rst_status",  c_sel_status,  32'h10000000);
        expect_push("rst_cause",   c_sel_cause,   32'd0);
        expect_push("rst_epc",     c_sel_epc,     32'd0);
        expect_push("rst_config",  c_sel_config,  c_config);
        expect_push("rst_prid",    c_sel_prid,    c_prid);
        expect_push("rst_timer",   c_sel_timer,   32'd0);
        expect_push("rst_rd_prid", c_sel_data,    c_prid);
        step();

        rst = 1'b0;
        for (int i = 0; i < 9; i++) step();
        expect_push("idle_count",  c_sel_count,  32'd10);
        expect_push("idle_timer",  c_sel_timer,  32'd0);
        expect_push("idle_status", c_sel_status, 32'h10000000);
        step();

        sw_write(5'd9, 32'd5);
        expect_push("cnt_load", c_sel_count, 32'd5);
        step();
        sw_write(5'd11, 32'd20);
        expect_push("cmp_load",     c_sel_compare, 32'd20);
        expect_push("cnt_after_ld", c_sel_count,   32'd6);
        step();
        for (int i = 0; i < 13; i++) step();
        expect_push("tmr_pre",   c_sel_timer, 32'd0);
        expect_push("cnt_eq",    c_sel_count, 32'd20);
        step();
        expect_push("tmr_rise",  c_sel_timer, 32'd1);
        expect_push("cnt_21",    c_sel_count, 32'd21);
        step();
        for (int i = 0; i < 3; i++) begin
            expect_push("tmr_hold", c_sel_timer, 32'd1);
            step();
        end
        raddr_i = 5'd11;
        sw_write(5'd11, 32'd100);
        expect_push("tmr_clear", c_sel_timer,   32'd0);
        expect_push("cmp_100",   c_sel_compare, 32'd100);
        expect_push("rd_cmp",    c_sel_data,    32'd100);
        step();

        sw_write(5'd9, 32'hFFFFFFFF);
        expect_push("cnt_max",  c_sel_count, 32'hFFFFFFFF);
        step();
        expect_push("cnt_wrap", c_sel_count, 32'd0);
        step();

        raddr_i = 5'd14;
        raise(32'h8, 32'h100, 1'b0);
        expect_push("sys_epc",    c_sel_epc,    32'h100);
        expect_push("sys_cause",  c_sel_cause,  32'h00000020);
        expect_push("sys_status", c_sel_status, 32'h10000002);
        expect_push("sys_rd_epc", c_sel_data,   32'h100);
        step();
        raise(32'hd, 32'h200, 1'b0);
        expect_push("trap_epc",    c_sel_epc,    32'h100);
        expect_push("trap_cause",  c_sel_cause,  32'h00000034);
        expect_push("trap_status", c_sel_status, 32'h10000002);
        step();
        raise(32'he, 32'h0, 1'b0);
        expect_push("eret1_status", c_sel_status, 32'h10000000);
        expect_push("eret1_epc",    c_sel_epc,    32'h100);
        step();

        raise(32'h1, 32'h304, 1'b1);
        expect_push("int_epc",    c_sel_epc,    32'h300);
        expect_push("int_cause",  c_sel_cause,  32'h80000000);
        expect_push("int_status", c_sel_status, 32'h10000002);
        step();
        raise(32'he, 32'h0, 1'b0);
        expect_push("eret2_status", c_sel_status, 32'h10000000);
        expect_push("eret2_epc",    c_sel_epc,    32'h300);
        expect_push("eret2_cause",  c_sel_cause,  32'h80000000);
        step();

        // BD stays from the delay-slot interrupt; software cannot touch it.
        int_i = 6'b100001;
        expect_push("ip_latch", c_sel_cause, 32'h80008400);
        step();
        sw_write(5'd13, 32'hFFFFFFFF);
        expect_push("cause_wr", c_sel_cause, 32'h80C08700);
        step();

        int_i = 6'b000000;
        sw_write(5'd12, 32'h0);
        raise(32'hc, 32'h400, 1'b0);
        expect_push("ov_status", c_sel_status, 32'h00000002);
        expect_push("ov_epc",    c_sel_epc,    32'h400);
        expect_push("ov_cause",  c_sel_cause,  32'h00C00330);
        step();

        raddr_i = 5'd15;
        sw_write(5'd15, 32'hDEADBEEF);
        expect_push("prid_ro",    c_sel_prid, c_prid);
        expect_push("rd_prid_ro", c_sel_data, c_prid);
        step();
        raddr_i = 5'd16;
        sw_write(5'd16, 32'h12345678);
        expect_push("cfg_ro",    c_sel_config, c_config);
        expect_push("rd_cfg_ro", c_sel_data,   c_config);
        step();

        raddr_i = 5'd8;
`ifdef CP0_BADVADDR_EN
        badvaddr_i = 32'h0000_0ABC;
        raise(32'h4, 32'h500, 1'b0);
        expect_push("adel_badva", c_sel_badva, 32'h0000_0ABC);
        expect_push("adel_rd",    c_sel_data,  32'h0000_0ABC);
        expect_push("adel_cause", c_sel_cause, 32'h00C00310);
        expect_push("adel_epc",   c_sel_epc,   32'h400);
`else
        raise(32'h4, 32'h500, 1'b0);
        expect_push("rd_reg8",    c_sel_data,  32'd0);
        expect_push("code4_cause", c_sel_cause, 32'h00C00330);
        expect_push("code4_epc",   c_sel_epc,   32'h400);
`endif
        step();

        raddr_i = 5'd10;
        raise(32'h7, 32'h600, 1'b0);
        expect_push("rd_reg10",    c_sel_data,   32'd0);
        expect_push("code7_status", c_sel_status, 32'h00000002);
        expect_push("code7_epc",    c_sel_epc,    32'h400);
        step();

        rst = 1'b1;
        sw_write(5'd11, 32'd77);
        raise(32'h8, 32'h700, 1'b1);
        expect_push("mrst_count",   c_sel_count,   32'd0);
        expect_push("mrst_compare", c_sel_compare, 32'd0);
        expect_push("mrst_status",  c_sel_status,  32'h10000000);
        expect_push("mrst_cause",   c_sel_cause,   32'd0);
        expect_push("mrst_epc",     c_sel_epc,     32'd0);
        expect_push("mrst_timer",   c_sel_timer,   32'd0);
        step();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- MIPS32 coprocessor-0 register file sitting directly downstream of the MEM/WB pipeline register.
- Consumes the write-back CP0 write triple: write enable, 5-bit address, 32-bit data.
- Also takes exception information resolved in the MEM stage, hardware interrupt lines and a free-running timer.
- Supplies Status/Cause/EPC to the exception logic and a read port to the EX stage.

Parameters:
- PRID_VALUE, 32'h00480102, reset/constant value of PRId (reg 15).
- CONFIG_VALUE, 32'h00008000, reset/constant value of Config (reg 16); BE=1, big-endian.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- we_i  in  1  CP0 write enable from write-back
- waddr_i  in  5  CP0 write register number
- wdata_i  in  32  CP0 write data
- raddr_i  in  5  CP0 read register number
- int_i  in  6  external hardware interrupt lines, level-sensitive
- excepttype_i  in  32  exception code from MEM stage; 0 means none
- current_inst_addr_i  in  32  PC of the excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot
- data_o  out  32  combinational read data for raddr_i
- count_o  out  32  Count (reg 9)
- compare_o  out  32  Compare (reg 11)
- status_o  out  32  Status (reg 12)
- cause_o  out  32  Cause (reg 13)
- epc_o  out  32  EPC (reg 14)
- config_o  out  32  Config (reg 16)
- prid_o  out  32  PRId (reg 15)
- timer_int_o  out  1  timer interrupt request

Behaviour:
- Reset: synchronous, active-high; reset rst, synchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values: count 0, compare 0, status 32'h10000000 (CU0=1), cause 0, epc 0, config CONFIG_VALUE, prid PRID_VALUE, timer_int_o 0.
- Count: increments by 1 every non-reset cycle and wraps 32'hFFFFFFFF -> 0. A software write to reg 9 loads wdata_i instead of incrementing that cycle.
- Timer interrupt:
  - timer_int_o is set next edge when compare != 0 and count == compare, comparing registered values.
  - Stays set until a software write to Compare, which loads compare and clears timer_int_o in the same edge.
  - Compare == 0 never raises the interrupt.
- Cause:
  - cause[15:10] <= int_i every cycle (one-cycle registered latency).
  - Software write to reg 13 updates only IP[9:8], WP[22] and IV[23]; other bits are ignored.
- Status and EPC: writes to reg 12 and reg 14 are full 32-bit. Writes to reg 15 and 16 are ignored; both are constant outputs.
- Exceptions, applied after any software write in the same edge, so they override touched fields:
  - 32'h1 interrupt: ExcCode 0.
  - 32'h8 syscall: ExcCode 8.
  - 32'ha reserved instruction: ExcCode 10.
  - 32'hd trap: ExcCode 13.
  - 32'hc overflow: ExcCode 12.
  - For all of the above: status[1] (EXL) <= 1 and cause[6:2] <= ExcCode.
    - If EXL was 0 before the edge: epc <= current_inst_addr_i - 4 and cause[31] (BD) <= 1 when is_in_delayslot_i is set; else epc <= current_inst_addr_i and BD <= 0.
    - If EXL was already 1: epc and BD are unchanged.
  - 32'he eret: status[1] <= 0; nothing else changes.
  - Any other nonzero code: no effect.
- Read port:
  - data_o is a combinational mux of registered values: 9, 11, 12, 13, 14, 15, 16 return the named register; any other address returns 0.
  - No internal write-to-read forwarding; forwarding is handled upstream.
- Reset mid-operation: rst overrides every pending write, exception and timer event.

Optional Feature:
- Macro CP0_BADVADDR_EN.
- Enabled:
  - Adds input badvaddr_i[31:0], register reg 8 BadVAddr (reset 0) and output badvaddr_o.
  - Codes 32'h4 (AdEL, ExcCode 4) and 32'h5 (AdES, ExcCode 5) become valid exceptions with the standard EXL/EPC rules, and load badvaddr <= badvaddr_i.
  - reg 8 is read-only to software.
- Disabled: reg 8 reads 0, codes 4/5 have no effect, and the extra port and register are absent.

Test Plan:
- Reset then 10 idle cycles -> count_o == 10, status_o == 32'h10000000, prid_o == PRID_VALUE, timer_int_o == 0.
- Write compare = 20 at count 5 -> timer_int_o rises the edge after count == 20, holds; a later compare write of 100 clears it in the same edge.
- Syscall at PC 32'h100, not in delay slot, EXL=0 -> epc 32'h100, cause[6:2] 8, BD 0, status[1] 1. A second trap at PC 32'h200 -> epc still 32'h100, ExcCode 13.
- Interrupt at PC 32'h304 with delayslot=1 -> epc 32'h300, cause[31] 1. Then eret -> status[1] 0, epc unchanged.
- int_i = 6'b100001 -> cause[15:10] == 6'b100001 one edge later. Software write of 32'hFFFFFFFF to cause -> only bits 23, 22, 9, 8 set, plus IP.
- Same-edge software write status = 0 and overflow exception -> status[1] == 1, ExcCode 12. A write to reg 15 leaves prid_o unchanged.
